datapath_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 26 ++
 rtl/data_mem.sv | 35 +++
 rtl/datapath_unit.sv | 95 +++++++++
 tb/tb_datapath_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the Prac6 CPU: datapath widths, ALU opcodes and the
// instruction-class codes the control unit also decodes.
package cpu_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS  = 5;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOT   = 4'b0101;
  localparam logic [3:0] OP_SHL   = 4'b0110;
  localparam logic [3:0] OP_SHR   = 4'b0111;
  localparam logic [3:0] OP_PASSB = 4'b1000;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  typedef enum logic [1:0] {
    IC_NONE  = 2'b00,
    IC_STD   = 2'b01,
    IC_LOAD  = 2'b10,
    IC_STORE = 2'b11
  } instr_class_e;

endpackage

// File: rtl/data_mem.sv
// Data memory: synchronous write, registered read-first output, and an
// asynchronous active-low clear of every word and the read register.
module data_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The read samples the array before this edge's write lands, so a
  // same-address read/write returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/datapath_unit.sv
// Executing end of the control-unit interface: registered ALU, data memory
// addressed by the ALU register, and the result2 select mux.
module datapath_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero,
  output logic                  carry
);

  // No valid/ready: every input is sampled on every rising edge and the
  // control unit's FSM sequences addresses, writes and result capture.

  logic [DATA_WIDTH-1:0] alu_q, alu_d, mem_q;
  logic [DATA_WIDTH-1:0] a, b;
  logic [DATA_WIDTH:0]   sum;
  logic [3:0]            op;
  logic                  zero_d, carry_d;

  always_comb begin
    a       = operand1;
    b       = sel3 ? offset : operand2;
    op      = sel3 ? OP_ADD : opcode;
    sum     = '0;
    alu_d   = '0;
    carry_d = 1'b0;
    zero_d  = zero;
    case (op)
      OP_ADD: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_d   = sum[DATA_WIDTH-1:0];
        carry_d = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_d   = a - b;
        carry_d = (a < b);
      end
      OP_AND:   alu_d = a & b;
      OP_OR:    alu_d = a | b;
      OP_XOR:   alu_d = a ^ b;
      OP_NOT:   alu_d = ~a;
      OP_SHL:   alu_d = {a[DATA_WIDTH-2:0], 1'b0};
      OP_SHR:   alu_d = {1'b0, a[DATA_WIDTH-1:1]};
      OP_PASSB: alu_d = b;
      OP_NOP: begin
        alu_d   = alu_q;
        carry_d = carry;
      end
      default:  alu_d = '0;
    endcase
    if (op != OP_NOP) begin
      zero_d = (alu_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else begin
      alu_q <= alu_d;
      zero  <= zero_d;
      carry <= carry_d;
    end
  end

  // Upper ALU bits are ignored for addressing, so addresses wrap.
  data_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_data_mem (
    .clk   (clk),
    .rst_n (rst),
    .we    (w_r),
    .addr  (alu_q[ADDR_BITS-1:0]),
    .wdata (operand2),
    .rdata (mem_q)
  );

  assign result2 = sel1 ? alu_q : mem_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed and randomized bench for datapath_unit against an arithmetic
// reference model of the ALU register, memory array and read register.
module tb_datapath_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] operand1, operand2, offset;
  logic [3:0] opcode;
  logic       sel1, sel3, w_r;
  logic [7:0] result2;
  logic       zero, carry;

  int vectors = 0;
  int miscompares = 0;

  int alu_m, zero_m, carry_m, memq_m;
  int mem_m [32];
  logic [7:0] exp_q [$];

  datapath_unit dut (
    .clk      (clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .offset   (offset),
    .opcode   (opcode),
    .sel1     (sel1),
    .sel3     (sel3),
    .w_r      (w_r),
    .result2  (result2),
    .zero     (zero),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    alu_m = 0; zero_m = 0; carry_m = 0; memq_m = 0;
    for (int i = 0; i < 32; i++) mem_m[i] = 0;
  endtask

  // One rising edge with the current inputs, described arithmetically.
  task automatic model_edge();
    int a, b, op, addr, s;
    a    = int'(operand1);
    b    = sel3 ? int'(offset) : int'(operand2);
    op   = sel3 ? 0 : int'(opcode);
    addr = alu_m % 32;
    memq_m = mem_m[addr];
    if (w_r) mem_m[addr] = int'(operand2);
    if (op == 15) return;
    carry_m = 0;
    case (op)
      0: begin s = a + b; alu_m = s % 256; carry_m = (s > 255) ? 1 : 0; end
      1: begin alu_m = (a - b + 256) % 256; carry_m = (a < b) ? 1 : 0; end
      2: alu_m = a & b;
      3: alu_m = a | b;
      4: alu_m = a ^ b;
      5: alu_m = 255 - a;
      6: alu_m = (a * 2) % 256;
      7: alu_m = a / 2;
      8: alu_m = b;
      default: alu_m = 0;
    endcase
    zero_m = (alu_m == 0) ? 1 : 0;
  endtask

  function automatic logic [7:0] model_result();
    return sel1 ? 8'(alu_m) : 8'(memq_m);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_result2"}, result2, e);
    check({tag, "_zero"}, {7'd0, zero}, 8'(zero_m));
    check({tag, "_carry"}, {7'd0, carry}, 8'(carry_m));
  endtask

  // Inputs change only on the falling edge; outputs are checked there too.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_edge();
    exp_q.push_back(model_result());
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic set_ops(input logic [7:0] o1, input logic [7:0] o2, input logic [7:0] off,
                         input logic [3:0] op, input logic s1, input logic s3, input logic wr);
    operand1 = o1; operand2 = o2; offset = off; opcode = op;
    sel1 = s1; sel3 = s3; w_r = wr;
  endtask

  task automatic dump_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      set_ops(8'h00, 8'(i), 8'h00, 4'b1000, 1'b0, 1'b0, 1'b0);
      step(tag);
      step(tag);
      check({tag, "_word"}, result2, 8'h00);
    end
  endtask

  initial begin
    rst = 1'b0;
    set_ops(8'h00, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(model_result());
    check_all("reset");
    rst = 1'b1;

    // ADD, including wrap with carry out
    set_ops(8'd2, 8'd3, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    step("add");
    check("add_val", result2, 8'd5);
    set_ops(8'hFF, 8'h01, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    step("add_wrap");
    check("add_wrap_val", result2, 8'h00);
    check("add_wrap_zero", {7'd0, zero}, 8'd1);
    check("add_wrap_carry", {7'd0, carry}, 8'd1);

    // SUB with borrow, then NOP holds everything
    set_ops(8'd1, 8'd3, 8'h00, 4'b0001, 1'b1, 1'b0, 1'b0);
    step("sub");
    check("sub_val", result2, 8'hFE);
    check("sub_borrow", {7'd0, carry}, 8'd1);
    opcode = 4'b1111;
    step("nop");
    check("nop_val", result2, 8'hFE);
    check("nop_carry", {7'd0, carry}, 8'd1);

    // Store A5 at 2+5, then load it back
    set_ops(8'd2, 8'hA5, 8'd5, 4'b0000, 1'b1, 1'b1, 1'b0);
    step("st_addr");
    check("st_addr_val", result2, 8'd7);
    w_r = 1'b1;
    step("st_write");
    w_r = 1'b0;
    sel1 = 1'b0;
    operand2 = 8'h00;
    step("ld_addr");
    step("ld_data");
    check("ld_data_val", result2, 8'hA5);

    // 30+5 wraps to address 3; write and read same edge returns old word
    set_ops(8'd30, 8'h00, 8'd5, 4'b0000, 1'b0, 1'b1, 1'b0);
    step("wrap_addr");
    operand2 = 8'h3C;
    w_r = 1'b1;
    step("rf_same_edge");
    check("rf_old", result2, 8'h00);
    w_r = 1'b0;
    step("rf_next");
    check("rf_new", result2, 8'h3C);

    // Mid-cycle reset clears registers immediately, then memory
    set_ops(8'h00, 8'h55, 8'h00, 4'b1000, 1'b1, 1'b0, 1'b0);
    step("pass55");
    check("pass55_val", result2, 8'h55);
    #2 rst = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(model_result());
    check_all("async_rst");
    check("async_rst_val", result2, 8'h00);
    sel1 = 1'b0;
    #1 check("async_rst_mem", result2, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    dump_zero("dump1");

    // Reset between address capture and write of a store aborts the write
    set_ops(8'd10, 8'h00, 8'd4, 4'b0000, 1'b1, 1'b1, 1'b0);
    step("st2_addr");
    operand2 = 8'h99;
    w_r = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    step("st2_abort");
    check("st2_abort_val", result2, 8'h00);
    w_r = 1'b0;
    rst = 1'b1;
    dump_zero("dump2");

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      set_ops(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
